// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - CPU/video arbiter for a single-port synchronous VRAM
//
// Shares one single-port VRAM (registered read, 1-cycle latency) between the
// uPD7800 CPU bus and the video fetch engine. Video has fixed priority. A
// saturating wait counter bounds how long a pending CPU access can be denied.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   cpu_cs              VRAM chip select from CPU address decode
//   cpu_rdb, cpu_wrb    CPU read/write strobes, active low
//   cpu_a, cpu_di       CPU address / write data
//   cpu_do, cpu_dv      last CPU read data (held) / 1-cycle update pulse
//   cpu_busy            CPU access pending, not yet granted
//   vid_req, vid_a      video fetch request (level) / fetch address
//   vid_ack             1-cycle pulse: vid_a sampled this cycle
//   vid_do, vid_dv      video read data / 1-cycle valid, one cycle after vid_ack
//   ram_a, ram_di       VRAM address / write data (combinational from grant)
//   ram_we              VRAM write enable
//   ram_do              VRAM read data, one cycle after address
module vram_arbiter #(
  parameter int AW           = 12,
  parameter int DW           = 8,
  parameter int CPU_MAX_WAIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_cs,
  input  logic          cpu_rdb,
  input  logic          cpu_wrb,
  input  logic [AW-1:0] cpu_a,
  input  logic [DW-1:0] cpu_di,
  output logic [DW-1:0] cpu_do,
  output logic          cpu_dv,
  output logic          cpu_busy,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_a,
  output logic          vid_ack,
  output logic [DW-1:0] vid_do,
  output logic          vid_dv,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_di,
  output logic          ram_we,
  input  logic [DW-1:0] ram_do
);

  localparam int WW = (CPU_MAX_WAIT < 1) ? 1 : $clog2(CPU_MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(CPU_MAX_WAIT);

  // What the RAM output will hold on the following cycle.
  typedef enum logic [1:0] {
    GNT_IDLE   = 2'd0,
    GNT_VID    = 2'd1,
    GNT_CPU_RD = 2'd2
  } gnt_e;

  gnt_e          gnt_q, gnt_d;
  logic          act, act_q, start;
  logic          pend_q, wr_q;
  logic [AW-1:0] a_q;
  logic [DW-1:0] di_q;
  logic [WW-1:0] wait_q;
  logic [DW-1:0] cpu_do_q, vid_do_q;
  logic          gnt_cpu, gnt_vid;

  // One access per strobe: only the rising edge of the active condition starts one.
  assign act   = cpu_cs & (~cpu_rdb | ~cpu_wrb);
  assign start = act & ~act_q;

  always_comb begin
    gnt_cpu = pend_q & ((wait_q == WAIT_MAX) | ~vid_req);
    // Video grant is masked during reset so every output reads 0 while rst is high.
    gnt_vid = ~gnt_cpu & vid_req & ~rst;
    ram_a   = '0;
    ram_di  = '0;
    ram_we  = 1'b0;
    vid_ack = 1'b0;
    gnt_d   = GNT_IDLE;
    if (gnt_cpu) begin
      ram_a = a_q;
      if (wr_q) begin
        ram_we = 1'b1;
        ram_di = di_q;
      end else begin
        gnt_d = GNT_CPU_RD;
      end
    end else if (gnt_vid) begin
      vid_ack = 1'b1;
      ram_a   = vid_a;
      gnt_d   = GNT_VID;
    end
  end

  // Read data is steered straight from the RAM in the return cycle, then held.
  assign cpu_dv   = (gnt_q == GNT_CPU_RD);
  assign vid_dv   = (gnt_q == GNT_VID);
  assign cpu_do   = cpu_dv ? ram_do : cpu_do_q;
  assign vid_do   = vid_dv ? ram_do : vid_do_q;
  assign cpu_busy = pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q    <= GNT_IDLE;
      act_q    <= 1'b0;
      pend_q   <= 1'b0;
      wr_q     <= 1'b0;
      a_q      <= '0;
      di_q     <= '0;
      wait_q   <= '0;
      cpu_do_q <= '0;
      vid_do_q <= '0;
    end else begin
      gnt_q <= gnt_d;
      act_q <= act;
      // A start in the grant cycle replaces the slot after the old access is issued.
      if (start) begin
        a_q  <= cpu_a;
        di_q <= cpu_di;
        wr_q <= ~cpu_wrb;
      end
      pend_q <= start | (pend_q & ~gnt_cpu);
      if (gnt_cpu) begin
        wait_q <= '0;
      end else if (pend_q && (wait_q != WAIT_MAX)) begin
        wait_q <= wait_q + 1'b1;
      end
      if (cpu_dv) cpu_do_q <= ram_do;
      if (vid_dv) vid_do_q <= ram_do;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed self-checking bench for vram_arbiter
module tb_vram_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_cs, cpu_rdb, cpu_wrb;
  logic [11:0] cpu_a;
  logic [7:0]  cpu_di;
  logic [7:0]  cpu_do;
  logic        cpu_dv, cpu_busy;
  logic        vid_req;
  logic [11:0] vid_a;
  logic        vid_ack;
  logic [7:0]  vid_do;
  logic        vid_dv;
  logic [11:0] ram_a;
  logic [7:0]  ram_di;
  logic        ram_we;
  logic [7:0]  ram_do;

  logic [7:0]  mem [0:4095];

  int tests;
  int fails;

  vram_arbiter #(.AW(12), .DW(8), .CPU_MAX_WAIT(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_cs   (cpu_cs),
    .cpu_rdb  (cpu_rdb),
    .cpu_wrb  (cpu_wrb),
    .cpu_a    (cpu_a),
    .cpu_di   (cpu_di),
    .cpu_do   (cpu_do),
    .cpu_dv   (cpu_dv),
    .cpu_busy (cpu_busy),
    .vid_req  (vid_req),
    .vid_a    (vid_a),
    .vid_ack  (vid_ack),
    .vid_do   (vid_do),
    .vid_dv   (vid_dv),
    .ram_a    (ram_a),
    .ram_di   (ram_di),
    .ram_we   (ram_we),
    .ram_do   (ram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM macro: synchronous write, registered read.
  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_di;
    ram_do <= mem[ram_a];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " cpu_do"},   32'(cpu_do),   32'h0);
    chk({tag, " cpu_dv"},   32'(cpu_dv),   32'h0);
    chk({tag, " cpu_busy"}, 32'(cpu_busy), 32'h0);
    chk({tag, " vid_ack"},  32'(vid_ack),  32'h0);
    chk({tag, " vid_do"},   32'(vid_do),   32'h0);
    chk({tag, " vid_dv"},   32'(vid_dv),   32'h0);
    chk({tag, " ram_a"},    32'(ram_a),    32'h0);
    chk({tag, " ram_di"},   32'(ram_di),   32'h0);
    chk({tag, " ram_we"},   32'(ram_we),   32'h0);
  endtask

  int busy_cnt;
  int dv_cnt;

  initial begin
    tests    = 0;
    fails    = 0;
    rst      = 1'b1;
    cpu_cs   = 1'b0;
    cpu_rdb  = 1'b1;
    cpu_wrb  = 1'b1;
    cpu_a    = '0;
    cpu_di   = '0;
    vid_req  = 1'b1;
    vid_a    = 12'h155;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h123] = 8'h5A;
    for (int i = 0; i < 8; i++) mem[12'h200 + i] = 8'(8'h40 + i * 7);

    // Reset state, with a video request present that must be ignored.
    tick;
    sample;
    chk_all_zero("rst");
    tick;
    vid_req = 1'b0;
    rst     = 1'b0;

    // 1: reset asserted in the cycle a CPU read is granted.
    tick;
    cpu_cs = 1'b1; cpu_rdb = 1'b0; cpu_a = 12'h123;
    sample;
    chk("t1 busy before grant", 32'(cpu_busy), 32'h0);
    tick;
    sample;
    chk("t1 grant ram_a", 32'(ram_a), 32'h123);
    rst = 1'b1; cpu_cs = 1'b0; cpu_rdb = 1'b1;
    #1;
    chk_all_zero("t1 in reset");
    tick;
    sample;
    chk("t1 dv during reset", 32'(cpu_dv), 32'h0);
    tick;
    rst = 1'b0;
    sample;
    chk("t1 dv after reset", 32'(cpu_dv), 32'h0);
    tick;
    sample;
    chk("t1 dv later", 32'(cpu_dv), 32'h0);
    chk("t1 do later", 32'(cpu_do), 32'h0);

    // 2: idle CPU read of 0x123.
    tick;
    cpu_cs = 1'b1; cpu_rdb = 1'b0; cpu_a = 12'h123;
    sample;
    chk("t2 t0 busy", 32'(cpu_busy), 32'h0);
    tick;
    sample;
    chk("t2 t1 ram_a", 32'(ram_a), 32'h123);
    chk("t2 t1 ram_we", 32'(ram_we), 32'h0);
    chk("t2 t1 busy", 32'(cpu_busy), 32'h1);
    chk("t2 t1 dv", 32'(cpu_dv), 32'h0);
    tick;
    cpu_cs = 1'b0; cpu_rdb = 1'b1;
    sample;
    chk("t2 t2 dv", 32'(cpu_dv), 32'h1);
    chk("t2 t2 do", 32'(cpu_do), 32'h5A);
    chk("t2 t2 busy", 32'(cpu_busy), 32'h0);
    tick;
    sample;
    chk("t2 t3 dv", 32'(cpu_dv), 32'h0);
    chk("t2 t3 do held", 32'(cpu_do), 32'h5A);

    // 3: starvation bound with video held high.
    tick;
    vid_req = 1'b1; vid_a = 12'h300;
    cpu_cs = 1'b1; cpu_wrb = 1'b0; cpu_a = 12'h010; cpu_di = 8'h3C;
    sample;
    chk("t3 s ack", 32'(vid_ack), 32'h1);
    for (int k = 1; k <= 3; k++) begin
      tick;
      if (k == 2) begin
        cpu_cs = 1'b0; cpu_wrb = 1'b1;
      end
      sample;
      chk($sformatf("t3 s+%0d ack", k), 32'(vid_ack), 32'h1);
      chk($sformatf("t3 s+%0d we", k), 32'(ram_we), 32'h0);
      chk($sformatf("t3 s+%0d busy", k), 32'(cpu_busy), 32'h1);
    end
    tick;
    sample;
    chk("t3 s+4 we", 32'(ram_we), 32'h1);
    chk("t3 s+4 ram_a", 32'(ram_a), 32'h010);
    chk("t3 s+4 ram_di", 32'(ram_di), 32'h3C);
    chk("t3 s+4 ack", 32'(vid_ack), 32'h0);
    tick;
    sample;
    chk("t3 s+5 ack", 32'(vid_ack), 32'h1);
    chk("t3 s+5 we", 32'(ram_we), 32'h0);
    chk("t3 s+5 busy", 32'(cpu_busy), 32'h0);
    tick;
    vid_req = 1'b0;
    tick;
    tick;

    // 4: video stream 0x200..0x207.
    for (int i = 0; i <= 8; i++) begin
      tick;
      if (i < 8) begin
        vid_req = 1'b1;
        vid_a   = 12'(12'h200 + i);
      end else begin
        vid_req = 1'b0;
      end
      sample;
      if (i < 8) begin
        chk($sformatf("t4 ack %0d", i), 32'(vid_ack), 32'h1);
        chk($sformatf("t4 ram_a %0d", i), 32'(ram_a), 32'(12'h200 + i));
      end else begin
        chk("t4 ack end", 32'(vid_ack), 32'h0);
      end
      if (i == 0) begin
        chk("t4 dv first", 32'(vid_dv), 32'h0);
      end else begin
        chk($sformatf("t4 dv %0d", i - 1), 32'(vid_dv), 32'h1);
        chk($sformatf("t4 do %0d", i - 1), 32'(vid_do), 32'(8'(8'h40 + (i - 1) * 7)));
      end
    end
    tick;
    sample;
    chk("t4 dv after", 32'(vid_dv), 32'h0);
    chk("t4 do held", 32'(vid_do), 32'h71);

    // 5: write 0xA5 to 0x7F0, then read it back, video held high throughout.
    tick;
    vid_req = 1'b1; vid_a = 12'h300;
    cpu_cs = 1'b1; cpu_wrb = 1'b0; cpu_a = 12'h7F0; cpu_di = 8'hA5;
    tick;
    cpu_cs = 1'b0; cpu_wrb = 1'b1;
    tick;
    tick;
    tick;
    sample;
    chk("t5 wr we", 32'(ram_we), 32'h1);
    chk("t5 wr ram_a", 32'(ram_a), 32'h7F0);
    chk("t5 wr ram_di", 32'(ram_di), 32'hA5);
    tick;
    cpu_cs = 1'b1; cpu_rdb = 1'b0; cpu_a = 12'h7F0;
    sample;
    chk("t5 busy after wr", 32'(cpu_busy), 32'h0);
    chk("t5 rd start ack", 32'(vid_ack), 32'h1);
    for (int k = 1; k <= 3; k++) begin
      tick;
      if (k == 2) begin
        cpu_cs = 1'b0; cpu_rdb = 1'b1;
      end
      sample;
      chk($sformatf("t5 rd wait %0d busy", k), 32'(cpu_busy), 32'h1);
      chk($sformatf("t5 rd wait %0d ack", k), 32'(vid_ack), 32'h1);
    end
    tick;
    sample;
    chk("t5 rd ram_a", 32'(ram_a), 32'h7F0);
    chk("t5 rd we", 32'(ram_we), 32'h0);
    chk("t5 rd ack", 32'(vid_ack), 32'h0);
    tick;
    sample;
    chk("t5 rd dv", 32'(cpu_dv), 32'h1);
    chk("t5 rd do", 32'(cpu_do), 32'hA5);
    chk("t5 busy after rd", 32'(cpu_busy), 32'h0);
    chk("t5 vid resumes", 32'(vid_ack), 32'h1);
    tick;
    vid_req = 1'b0;
    tick;
    tick;

    // 6: read strobe held low for six cycles gives exactly one access.
    busy_cnt = 0;
    dv_cnt   = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (i == 0) begin
        cpu_cs = 1'b1; cpu_rdb = 1'b0; cpu_a = 12'h123;
      end
      if (i == 6) begin
        cpu_cs = 1'b0; cpu_rdb = 1'b1;
      end
      sample;
      busy_cnt += int'(cpu_busy);
      dv_cnt   += int'(cpu_dv);
    end
    chk("t6 grants", 32'(busy_cnt), 32'd1);
    chk("t6 dv pulses", 32'(dv_cnt), 32'd1);
    chk("t6 do", 32'(cpu_do), 32'h5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
